pcileech_sysctl: RTL and testbench

// - Parametrised system-control block for board top levels: power-on/button reset sequencer, free-running 64-bit tickcount, N-channel LED driver.
// - Per-LED mode select: off / on / heartbeat / activity-stretch, plus a global invert input.
// - Sits between board pads (buttons, LEDs) and the core; rst_out feeds pcileech_com/fifo/pcie and drives ft601_rst_n via rst_out_n.
//

---
 rtl/pcileech_sysctl.sv | 181 ++++++++++++++++++
 tb/tb_pcileech_sysctl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pcileech_sysctl.sv
// pcileech_sysctl: reset sequencer, 64-bit tickcount and LED driver.
// Optional button debounce: define PCILEECH_SYSCTL_DEBOUNCE_EN.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   btn_rst, btn_inv  async buttons (reset request, LED invert)
//   led_mode          2 bits per LED: off/on/heartbeat/activity
//   led_act           per-LED activity pulses (clk domain)
//   tickcount         free-running cycle counter
//   rst_out/_n        system reset to core, and its inverse
//   led               registered LED drive
module pcileech_sysctl #(
  parameter int NUM_LED         = 3,
  parameter int POR_CYCLES      = 64,
  parameter int BLINK_BIT       = 26,
  parameter int STRETCH_CYCLES  = 1 << 22,
  parameter int DEBOUNCE_CYCLES = 1 << 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_rst,
  input  logic                 btn_inv,
  input  logic [2*NUM_LED-1:0] led_mode,
  input  logic [NUM_LED-1:0]   led_act,
  output logic [63:0]          tickcount,
  output logic                 rst_out,
  output logic                 rst_out_n,
  output logic [NUM_LED-1:0]   led
);

  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [PW-1:0] POR_LAST =
    PW'(POR_CYCLES - 1);
  localparam logic [SW-1:0] S_LOAD =
    SW'(STRETCH_CYCLES);

  typedef enum logic {
    HOLD,
    RUN
  } state_t;

  state_t               state;
  logic [PW-1:0]        por_cnt;
  logic [1:0]           rst_sync;
  logic [1:0]           inv_sync;
  logic                 rst_c;
  logic                 inv_c;
  logic [NUM_LED-1:0]   led_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickcount <= '0;
    end else begin
      tickcount <= tickcount + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
      inv_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], btn_rst};
      inv_sync <= {inv_sync[0], btn_inv};
    end
  end

`ifdef PCILEECH_SYSCTL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] rst_db;
  logic [DW-1:0] inv_db;

  // Output flips only after a run of mismatching
  // samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_db <= '0;
      inv_db <= '0;
      rst_c  <= 1'b0;
      inv_c  <= 1'b0;
    end else begin
      if (rst_sync[1] != rst_c) begin
        if (rst_db == DB_LAST) begin
          rst_c  <= rst_sync[1];
          rst_db <= '0;
        end else begin
          rst_db <= rst_db + DW'(1);
        end
      end else begin
        rst_db <= '0;
      end
      if (inv_sync[1] != inv_c) begin
        if (inv_db == DB_LAST) begin
          inv_c  <= inv_sync[1];
          inv_db <= '0;
        end else begin
          inv_db <= inv_db + DW'(1);
        end
      end else begin
        inv_db <= '0;
      end
    end
  end
`else
  assign rst_c = rst_sync[1];
  assign inv_c = inv_sync[1];
`endif

  // A held button pins por_cnt at 0 so release
  // always yields the full hold time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD;
      por_cnt <= '0;
      rst_out <= 1'b1;
    end else begin
      unique case (state)
        HOLD: begin
          if (rst_c) begin
            por_cnt <= '0;
          end else if (por_cnt == POR_LAST) begin
            state   <= RUN;
            rst_out <= 1'b0;
          end else begin
            por_cnt <= por_cnt + PW'(1);
          end
        end
        RUN: begin
          if (rst_c) begin
            state   <= HOLD;
            por_cnt <= '0;
            rst_out <= 1'b1;
          end
        end
      endcase
    end
  end

  assign rst_out_n = ~rst_out;

  for (genvar i = 0; i < NUM_LED; i++) begin : g_led
    logic [SW-1:0] sc;
    logic [1:0]    m;

    assign m = led_mode[2*i +: 2];

    // Reload beats expiry; runs in every mode.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sc <= '0;
      end else if (led_act[i]) begin
        sc <= S_LOAD;
      end else if (sc != '0) begin
        sc <= sc - SW'(1);
      end
    end

    always_comb begin
      led_nxt[i] = 1'b0;
      unique case (m)
        2'b00: led_nxt[i] = 1'b0;
        2'b01: led_nxt[i] = 1'b1;
        2'b10: led_nxt[i] = tickcount[BLINK_BIT];
        2'b11: led_nxt[i] = |sc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_nxt ^ {NUM_LED{inv_c}};
    end
  end

endmodule

// File: tb/tb_pcileech_sysctl.sv
// tb_pcileech_sysctl: directed bench for pcileech_sysctl
// (default build, no debounce), scoreboard queue checks.
module tb_pcileech_sysctl;

  localparam int NL  = 3;
  localparam int POR = 64;
  localparam int BB  = 4;
  localparam int SC  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_rst;
  logic          btn_inv;
  logic [2*NL-1:0] led_mode;
  logic [NL-1:0] led_act;
  logic [63:0]   tickcount;
  logic          rst_out;
  logic          rst_out_n;
  logic [NL-1:0] led;

  logic [63:0]   sb[$];
  logic [63:0]   tc;
  int            nchk;
  int            npass;

  always #5 clk = ~clk;

  pcileech_sysctl #(
    .NUM_LED        (NL),
    .POR_CYCLES     (POR),
    .BLINK_BIT      (BB),
    .STRETCH_CYCLES (SC),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_rst  (btn_rst),
    .btn_inv  (btn_inv),
    .led_mode (led_mode),
    .led_act  (led_act),
    .tickcount(tickcount),
    .rst_out  (rst_out),
    .rst_out_n(rst_out_n),
    .led      (led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) tc = tc + 64'd1;
  endtask

  task automatic push(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs);
    logic [63:0] e;
    nchk++;
    if (sb.size() == 0) begin
      $error("FAIL %s obs=%0h scoreboard empty",
             tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e) npass++;
    else $error("FAIL %s obs=%0h exp=%0h",
                tag, obs, e);
  endtask

  // Button high for n edges starting at edge k=j0.
  // rst_out is 1 after edges k+2 .. k+n+64.
  task automatic btn_pulse(input int n,
                           input string tag);
    for (int j = 0; j < n + 68; j++) begin
      btn_rst = (j < n);
      push({63'd0, (j >= 2 && j <= n + 64)});
      push({63'd0, !(j >= 2 && j <= n + 64)});
      tick();
      check(tag, {63'd0, rst_out});
      check({tag, "_n"}, {63'd0, rst_out_n});
    end
    btn_rst = 1'b0;
  endtask

  initial begin
    nchk     = 0;
    npass    = 0;
    tc       = '0;
    rst_n    = 1'b0;
    btn_rst  = 1'b0;
    btn_inv  = 1'b0;
    led_mode = '0;
    led_act  = '0;
    repeat (3) tick();

    push(64'd1); check("rst_out_por", {63'd0, rst_out});
    push(64'd0); check("rst_n_por", {63'd0, rst_out_n});
    push(64'd0); check("tick_por", tickcount);
    push(64'd0); check("led_por", {61'd0, led});

    rst_n = 1'b1;
    for (int e = 1; e <= POR + 2; e++) begin
      push({63'd0, (e < POR)});
      push({63'd0, (e >= POR)});
      tick();
      check("por_seq", {63'd0, rst_out});
      check("por_seq_n", {63'd0, rst_out_n});
      if (e == POR) begin
        push(64'd64);
        check("tick_at_run", tickcount);
      end
    end

    btn_pulse(1, "btn1");
    btn_pulse(5, "btn5");
    push(tc);
    check("tick_no_clear", tickcount);

    led_mode = {2'b00, 2'b01, 2'b11};
    push(64'b010);
    tick();
    check("led_static", {61'd0, led});

    for (int j = 0; j < 12; j++) begin
      led_act[0] = (j == 0);
      push({61'd0, 2'b01, (j >= 1 && j <= SC)});
      tick();
      led_act = '0;
      check("stretch1", {61'd0, led});
    end

    for (int j = 0; j < 16; j++) begin
      led_act[0] = (j == 0 || j == 5);
      push({61'd0, 2'b01, (j >= 1 && j <= 13)});
      tick();
      led_act = '0;
      check("stretch2", {61'd0, led});
    end

    led_mode = {2'b00, 2'b01, 2'b10};
    for (int j = 0; j < 40; j++) begin
      push({61'd0, 2'b01, tc[BB]});
      tick();
      check("heartbeat", {61'd0, led});
    end

    led_mode = {2'b01, 2'b00, 2'b01};
    push(64'b101);
    tick();
    check("inv_pre", {61'd0, led});
    btn_inv = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push((j >= 2) ? 64'b010 : 64'b101);
      tick();
      check("invert", {61'd0, led});
    end

    rst_n = 1'b0;
    tc    = '0;
    #1;
    push(64'd1); check("arst_out", {63'd0, rst_out});
    push(64'd0); check("arst_out_n", {63'd0, rst_out_n});
    push(64'd0); check("arst_tick", tickcount);
    push(64'd0); check("arst_led", {61'd0, led});
    tick();
    push(64'd0); check("arst_hold_tick", tickcount);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
